// File: rtl/calc_ctrl_fsm.sv
// Keypad control FSM for the calculator: turns key presses into X/Y load/clear strobes, din and ALU select.
// Optional CALC_KEY_SYNC_EN adds a two-flop synchroniser on key_code/key_valid (+2 cycles press latency).
module calc_ctrl_fsm #(
    parameter logic [3:0] KEY_EQ  = 4'hE,
    parameter logic [3:0] KEY_CLR = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       ldX,
    output logic       ldY,
    output logic       clrX,
    output logic       clrY,
    output logic [3:0] din,
    output logic [2:0] s,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_X    = 3'd1,
        S_Y    = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t     state, state_d;
    logic [2:0] op, op_d;
    logic       y_set, y_set_d, y_zero, y_zero_d;
    logic       ldx_d, ldy_d, clrx_d, clry_d, err_d;
    logic [3:0] din_d;
    logic [2:0] s_d;

    logic       kv_in, key_valid_q, key_stb;
    logic [3:0] kc_in;
    logic       is_digit, is_op, is_eq, is_clr;
    logic [2:0] key_op;

`ifdef CALC_KEY_SYNC_EN
    logic       kv_s1, kv_s2;
    logic [3:0] kc_s1, kc_s2;

    // Sync flops reset high so a key held through reset is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kv_s1 <= 1'b1;
            kv_s2 <= 1'b1;
        end else begin
            kv_s1 <= key_valid;
            kv_s2 <= kv_s1;
        end
    end

    always_ff @(posedge clk) begin
        kc_s1 <= key_code;
        kc_s2 <= kc_s1;
    end

    assign kv_in = kv_s2;
    assign kc_in = kc_s2;
`else
    assign kv_in = key_valid;
    assign kc_in = key_code;
`endif

    assign key_stb  = kv_in & ~key_valid_q;
    assign is_digit = (kc_in <= 4'd9);
    assign is_op    = (kc_in >= 4'd10) && (kc_in <= 4'd13);
    assign is_eq    = (kc_in == KEY_EQ);
    assign is_clr   = (kc_in == KEY_CLR);
    // Codes 10..13 map to 0..3: low two bits plus 2 wrap around modulo 4
    assign key_op   = {1'b0, kc_in[1:0] + 2'd2};

    always_comb begin
        state_d  = state;
        op_d     = op;
        y_set_d  = y_set;
        y_zero_d = y_zero;
        din_d    = din;
        ldx_d    = 1'b0;
        ldy_d    = 1'b0;
        clrx_d   = 1'b0;
        clry_d   = 1'b0;
        if (key_stb) begin
            if (is_clr) begin
                clrx_d   = 1'b1;
                clry_d   = 1'b1;
                op_d     = 3'b000;
                y_set_d  = 1'b0;
                y_zero_d = 1'b0;
                state_d  = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (is_digit) begin
                        ldx_d   = 1'b1;
                        din_d   = kc_in;
                        state_d = S_X;
                    end
                    S_X: if (is_digit) begin
                        ldx_d = 1'b1;
                        din_d = kc_in;
                    end else if (is_op) begin
                        op_d    = key_op;
                        clry_d  = 1'b1;
                        y_set_d = 1'b0;
                        state_d = S_Y;
                    end
                    S_Y: if (is_digit) begin
                        ldy_d    = 1'b1;
                        din_d    = kc_in;
                        y_set_d  = 1'b1;
                        y_zero_d = (kc_in == 4'd0);
                    end else if (is_op) begin
                        op_d = key_op;
                    end else if (is_eq && y_set) begin
                        state_d = (op == 3'b011 && y_zero) ? S_ERR : S_RES;
                    end
                    // No chaining from a result: a digit starts a fresh X
                    S_RES: if (is_digit) begin
                        clry_d  = 1'b1;
                        ldx_d   = 1'b1;
                        din_d   = kc_in;
                        state_d = S_X;
                    end
                    default: ;
                endcase
            end
        end
        case (state_d)
            S_Y:     s_d = 3'b101;
            S_RES:   s_d = op_d;
            default: s_d = 3'b100;
        endcase
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op          <= 3'b000;
            y_set       <= 1'b0;
            y_zero      <= 1'b0;
            key_valid_q <= 1'b1;
            ldX         <= 1'b0;
            ldY         <= 1'b0;
            clrX        <= 1'b0;
            clrY        <= 1'b0;
            din         <= 4'd0;
            s           <= 3'b100;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            op          <= op_d;
            y_set       <= y_set_d;
            y_zero      <= y_zero_d;
            key_valid_q <= kv_in;
            ldX         <= ldx_d;
            ldY         <= ldy_d;
            clrX        <= clrx_d;
            clrY        <= clry_d;
            din         <= din_d;
            s           <= s_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Self-checking bench for calc_ctrl_fsm: calculator-level model checked every cycle plus literal checks.
module tb_calc_ctrl_fsm;

`ifdef CALC_KEY_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       ldX, ldY, clrX, clrY, err;
    logic [3:0] din;
    logic [2:0] s;

    always #5 clk = ~clk;

    calc_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .ldX       (ldX),
        .ldY       (ldY),
        .clrX      (clrX),
        .clrY      (clrY),
        .din       (din),
        .s         (s),
        .err       (err)
    );

    typedef struct packed {
        logic       ldx;
        logic       ldy;
        logic       clrx;
        logic       clry;
        logic [3:0] din;
        logic [2:0] s;
        logic       err;
    } outs_t;

    localparam outs_t RST_O = 13'b0000_0000_1000;

    int n_chk = 0, n_pass = 0;
    int c_ldx = 0, c_ldy = 0, c_clrx = 0, c_clry = 0;
    bit chk_en = 1'b0;
    outs_t exp_o = RST_O;
    outs_t q[$];

    // Calculator-level model: what has been entered so far
    bit         have_x, have_op, have_y, show_res, in_err, m_prev;
    int         m_op, m_y;
    logic [3:0] m_din;
    bit         p_ldx, p_ldy, p_clrx, p_clry;

    function automatic void model_reset();
        have_x = 0; have_op = 0; have_y = 0; show_res = 0; in_err = 0;
        m_op = 0; m_y = 0; m_din = 4'd0; m_prev = 1;
        p_ldx = 0; p_ldy = 0; p_clrx = 0; p_clry = 0;
    endfunction

    function automatic void apply_key(input int k);
        p_ldx = 0; p_ldy = 0; p_clrx = 0; p_clry = 0;
        if (k == 15) begin
            p_clrx = 1; p_clry = 1;
            have_x = 0; have_op = 0; have_y = 0; show_res = 0; in_err = 0; m_op = 0;
        end else if (in_err) begin
        end else if (k <= 9) begin
            m_din = 4'(k);
            if (show_res) begin
                p_clry = 1; p_ldx = 1; show_res = 0; have_op = 0; have_y = 0; have_x = 1;
            end else if (have_op) begin
                p_ldy = 1; have_y = 1; m_y = k;
            end else begin
                p_ldx = 1; have_x = 1;
            end
        end else if (k <= 13) begin
            if (show_res) begin
            end else if (have_op) begin
                m_op = k - 10;
            end else if (have_x) begin
                m_op = k - 10; have_op = 1; have_y = 0; p_clry = 1;
            end
        end else if (have_op && have_y && !show_res) begin
            if (m_op == 3 && m_y == 0) begin
                in_err = 1; have_op = 0; have_y = 0;
            end else begin
                show_res = 1;
            end
        end
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.ldx = p_ldx; o.ldy = p_ldy; o.clrx = p_clrx; o.clry = p_clry;
        o.din = m_din;
        o.err = in_err;
        if (in_err)        o.s = 3'd4;
        else if (show_res) o.s = 3'(m_op);
        else if (have_op)  o.s = 3'd5;
        else               o.s = 3'd4;
        return o;
    endfunction

    always @(negedge clk) begin
        outs_t a;
        if (chk_en) begin
            a = {ldX, ldY, clrX, clrY, din, s, err};
            n_chk++;
            if (a === exp_o) n_pass++;
            else $display("FAIL cycle_cmp t=%0t dut=%b model=%b", $time, a, exp_o);
            if (ldX)  c_ldx++;
            if (ldY)  c_ldy++;
            if (clrX) c_clrx++;
            if (clrY) c_clry++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic clr_cnt();
        c_ldx = 0; c_ldy = 0; c_clrx = 0; c_clry = 0;
    endtask

    task automatic step(input logic kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        if (kv && !m_prev) apply_key(int'(kc));
        else begin
            p_ldx = 0; p_ldy = 0; p_clrx = 0; p_clry = 0;
        end
        m_prev = kv;
        q.push_back(model_outs());
        @(posedge clk);
        #1;
        if (q.size() > LAT) exp_o = q.pop_front();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k);
        step(1'b0, k);
    endtask

    task automatic settle();
        repeat (LAT + 2) step(1'b0, 4'd0);
    endtask

    task automatic do_reset();
        chk_en = 0;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        repeat (2) @(negedge clk);
        model_reset();
        q.delete();
        exp_o = RST_O;
        rst_n = 1'b1;
        #1 chk_en = 1;
        step(1'b0, 4'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s", int'(s), 4);
        chk("rst_strobes", int'({ldX, ldY, clrX, clrY}), 0);
        chk("rst_din_err", int'({din, err}), 0);
        do_reset();

        // 3 + 4 =
        clr_cnt();
        press(4'd3); press(4'd10); press(4'd4); press(4'd14); settle();
        chk("add_s", int'(s), 0);
        chk("add_err", int'(err), 0);
        chk("add_din", int'(din), 4);
        chk("add_ldx_cnt", c_ldx, 1);
        chk("add_ldy_cnt", c_ldy, 1);
        chk("add_clry_cnt", c_clry, 1);
        chk("add_clrx_cnt", c_clrx, 0);

        // 7 / 0 = -> error, digit ignored, clear
        do_reset();
        press(4'd7); press(4'd13); press(4'd0); press(4'd14); settle();
        chk("div0_err", int'(err), 1);
        chk("div0_s", int'(s), 4);
        clr_cnt();
        press(4'd5); settle();
        chk("err_ignore_strobes", c_ldx + c_ldy + c_clrx + c_clry, 0);
        chk("err_ignore_din", int'(din), 0);
        press(4'd15); settle();
        chk("clr_clrx_cnt", c_clrx, 1);
        chk("clr_clry_cnt", c_clry, 1);
        chk("clr_err", int'(err), 0);
        chk("clr_s", int'(s), 4);

        // Hold 5 for 10 cycles
        do_reset();
        clr_cnt();
        repeat (10) step(1'b1, 4'd5);
        step(1'b0, 4'd5); settle();
        chk("hold_ldx_cnt", c_ldx, 1);
        chk("hold_din", int'(din), 5);

        // 9 * - 2 = then 6
        do_reset();
        press(4'd9); press(4'd12); press(4'd11); press(4'd2); press(4'd14); settle();
        chk("lastop_s", int'(s), 1);
        clr_cnt();
        press(4'd6); settle();
        chk("res_digit_s", int'(s), 4);
        chk("res_digit_din", int'(din), 6);
        chk("res_digit_clry", c_clry, 1);
        chk("res_digit_ldx", c_ldx, 1);

        // Ignored keys, '=' without Y, then reset mid-sequence
        do_reset();
        press(4'd10); press(4'd2); press(4'd14); press(4'd10); press(4'd14); settle();
        chk("noy_s", int'(s), 5);
        chk("noy_din", int'(din), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_s", int'(s), 4);
        chk("async_rst_din", int'(din), 0);
        chk("async_rst_err", int'({err, ldX, ldY, clrX, clrY}), 0);
        do_reset();

        // Press-to-ldX latency
        step(1'b1, 4'd1);
        n = 0;
        while (!ldX && n < 5) begin
            step(1'b0, 4'd0);
            n++;
        end
        chk("press_to_ldx_latency", n, LAT);
        settle();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
